// File: rtl/div_seq_ctrl.sv
// Programmable clock-divider sequencer: walks a {divisor, repeat} table to shape f_out.
// Define DIV_SEQ_IRQ_EN to add the irq / irq_clr interrupt ports.
module div_seq_ctrl #(
   parameter  int DW      = 8,
   parameter  int RW      = 4,
   parameter  int ENTRIES = 4,
   localparam int AW      = $clog2(ENTRIES)
) (
   input  logic          clk,
   input  logic          rst,
`ifdef DIV_SEQ_IRQ_EN
   input  logic          irq_clr,
   output logic          irq,
`endif
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [DW-1:0] cfg_div,
   input  logic [RW-1:0] cfg_rep,
   input  logic          start,
   input  logic          stop,
   input  logic          loop_en,
   output logic          f_out,
   output logic          busy,
   output logic [AW-1:0] idx,
   output logic          done,
   output logic          err
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

   state_t        state_reg;
   logic [DW-1:0] div_mem [ENTRIES];
   logic [RW-1:0] rep_mem [ENTRIES];
   logic [DW-1:0] cnt_reg;
   logic [DW-1:0] div_reg;
   logic [RW-1:0] rep_cnt_reg;
   logic          any_valid_reg;
   logic [DW-1:0] rd_div;
   logic [RW-1:0] rd_rep;
   state_t        adv_state_next;
   logic [AW-1:0] adv_idx_next;
   logic          adv_err_next;
   logic          adv_wrap_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            div_mem[i] <= DW'(50);
            rep_mem[i] <= RW'(1);
         end
      end else if (cfg_we) begin
         div_mem[cfg_addr] <= cfg_div;
         rep_mem[cfg_addr] <= cfg_rep;
      end
   end

   assign rd_div = div_mem[idx];
   assign rd_rep = rep_mem[idx];

   // End-of-table decision; a pass with no runnable entry always finishes with err.
   always_comb begin
      adv_state_next = FINISH;
      adv_idx_next   = idx;
      adv_err_next   = 1'b0;
      adv_wrap_next  = 1'b0;
      if (idx != AW'(ENTRIES - 1)) begin
         adv_state_next = LOAD;
         adv_idx_next   = idx + AW'(1);
      end else if (!any_valid_reg) begin
         adv_err_next = 1'b1;
      end else if (loop_en) begin
         adv_state_next = LOAD;
         adv_idx_next   = '0;
         adv_wrap_next  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         f_out         <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         idx           <= '0;
         cnt_reg       <= '0;
         div_reg       <= '0;
         rep_cnt_reg   <= '0;
         any_valid_reg <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               f_out <= 1'b0;
               if (start && !stop) begin
                  state_reg     <= LOAD;
                  busy          <= 1'b1;
                  idx           <= '0;
                  err           <= 1'b0;
                  any_valid_reg <= 1'b0;
               end
            end
            LOAD: begin
               if (stop) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                  f_out     <= 1'b0;
               end else if (rd_div != '0 && rd_rep != '0) begin
                  state_reg     <= RUN;
                  cnt_reg       <= rd_div;
                  div_reg       <= rd_div;
                  rep_cnt_reg   <= rd_rep;
                  f_out         <= 1'b1;
                  any_valid_reg <= 1'b1;
               end else begin
                  if (rd_div == '0 || adv_err_next)
                     err <= 1'b1;
                  state_reg <= adv_state_next;
                  idx       <= adv_idx_next;
                  if (adv_wrap_next)
                     any_valid_reg <= 1'b0;
                  if (adv_state_next == FINISH) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (stop) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
                  f_out     <= 1'b0;
               end else if (cnt_reg > DW'(1)) begin
                  cnt_reg <= cnt_reg - DW'(1);
               end else if (f_out) begin
                  f_out   <= 1'b0;
                  cnt_reg <= div_reg;
               end else if (rep_cnt_reg > RW'(1)) begin
                  rep_cnt_reg <= rep_cnt_reg - RW'(1);
                  f_out       <= 1'b1;
                  cnt_reg     <= div_reg;
               end else begin
                  if (adv_err_next)
                     err <= 1'b1;
                  state_reg <= adv_state_next;
                  idx       <= adv_idx_next;
                  if (adv_wrap_next)
                     any_valid_reg <= 1'b0;
                  if (adv_state_next == FINISH) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                  end
               end
            end
            FINISH: begin
               state_reg <= IDLE;
               f_out     <= 1'b0;
               busy      <= 1'b0;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef DIV_SEQ_IRQ_EN
   logic err_d_reg;

   // Set (done pulse or err rising) takes priority over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq       <= 1'b0;
         err_d_reg <= 1'b0;
      end else begin
         err_d_reg <= err;
         if (done || (err && !err_d_reg))
            irq <= 1'b1;
         else if (irq_clr)
            irq <= 1'b0;
      end
   end
`endif

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Programmable clock-divider sequencer. Holds a small table of {half-period divisor, repeat count} entries and walks through it on command, generating a square wave `f_out` whose frequency changes per entry. It sits between the control logic and the divided-clock consumers. It replaces fixed-constant dividers wherever a timed frequency sequence (e.g. tone or blink patterns) is needed.

Parameters:
- DW, 8, divisor width; half-period length in clk cycles, legal 1..2^DW-1
- RW, 4, repeat-count width; full f_out periods per entry
- ENTRIES, 4, table depth (power of 2); AW = log2(ENTRIES)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table entry index
- cfg_div  in  DW  divisor for written entry
- cfg_rep  in  RW  repeat count for written entry
- start  in  1  begin sequence (sampled in IDLE only)
- stop  in  1  abort sequence
- loop_en  in  1  wrap to entry 0 after last entry instead of finishing
- f_out  out  1  generated square wave
- busy  out  1  high in LOAD/RUN
- idx  out  AW  entry currently loaded/running
- done  out  1  one-cycle pulse on normal sequence completion
- err  out  1  sticky: divisor 0 was encountered, or a full pass ran no entry; cleared by next accepted start

Behaviour:
- Reset values:
  - table entries div = 8'd50 (8'b00110010), rep = 1
  - state IDLE; f_out, busy, done, err = 0; idx = 0; cnt = 0; rep_cnt = 0
- Reset is asynchronous and may occur mid-sequence; everything, including the table, returns to reset values.
- States: IDLE, LOAD, RUN, FINISH.
- IDLE:
  - start=1 and stop=0 -> LOAD; idx <= 0; err <= 0.
  - f_out held 0.
- LOAD (1 cycle) reads table[idx]:
  - div=0: set err, skip entry.
  - rep=0: skip entry silently.
  - Skip advances idx; advancing past the last entry follows the end-of-table rule.
  - Valid entry: cnt <= div, rep_cnt <= rep, f_out <= 1 -> RUN.
  - f_out is 0 during the LOAD cycle.
- RUN, each cycle:
  - cnt>1: cnt <= cnt-1.
  - cnt==1 with f_out==1: f_out <= 0, cnt <= div.
  - cnt==1 with f_out==0 (period end): if rep_cnt>1, then rep_cnt--, f_out <= 1, cnt <= div; else entry complete -> advance.
  - Result per entry: f_out high exactly div cycles, low exactly div cycles, for rep periods. The final low phase before the next entry is extended by the 1 LOAD cycle.
- Advance / end-of-table:
  - idx < ENTRIES-1: idx++ -> LOAD.
  - Else if loop_en: idx <= 0 -> LOAD.
  - Else -> FINISH.
  - If a complete pass (idx 0..ENTRIES-1) executes no valid entry, go to FINISH with err=1 regardless of loop_en; this prevents a spin in LOAD.
- FINISH (1 cycle): done=1, f_out=0, busy=0 -> IDLE.
- stop:
  - In LOAD/RUN: next state IDLE, f_out <= 0, no done pulse, idx retained.
  - stop and start in the same cycle: stop wins.
  - start while busy is ignored.
- cfg writes:
  - Accepted in any state; same cycle write and read at one address returns old data.
  - A write to the running entry takes effect at that entry's next LOAD; it does not change the current period.
- loop_en is sampled only at end-of-table.
- Width rules:
  - cnt is DW bits; rep_cnt is RW bits.
  - Divisor and repeat count are unsigned.
  - Maximum f_out period is 2*(2^DW-1) cycles.

Optional Feature:
- Macro: DIV_SEQ_IRQ_EN.
- Defined: adds ports `irq` (out, 1) and `irq_clr` (in, 1).
  - `irq` sets on a done pulse or on any err set event, and stays high until `irq_clr`=1.
  - A set and a clear in the same cycle: set wins.
  - `irq` resets to 0.
- Undefined: neither port exists, and the behaviour above is unchanged.

Test Plan:
- Reset, then start=1 for one cycle with the default table and loop_en=0:
  - 1 LOAD cycle, then f_out 50 high/50 low, repeated for idx 0..3.
  - Total 4*101 busy cycles, then FINISH.
  - done pulses once; busy=0 afterwards; err=0.
- Write entry0={div=3,rep=2} and entries1-3={div=1,rep=1}, then start:
  - f_out pattern 1110001110000 (entry0, including LOAD), then 10, 10, 10 for the remaining entries.
  - done after the last entry.
- Write entry1 div=0, then start:
  - entry1 skipped, with no RUN cycles at idx=1.
  - err=1 and stays set through done.
  - The next start clears err.
- Set all rep=0 with loop_en=1, then start:
  - one pass of LOAD cycles, then FINISH with err=1, done pulse, no f_out high cycle.
- loop_en=1 on the default table:
  - idx wraps 3->0 with no FINISH.
  - stop asserted at a RUN cycle with f_out=1 -> next cycle f_out=0, busy=0, no done.
  - start and stop together in IDLE -> stays IDLE.
- Assert rst mid-RUN with entry2 rewritten to div=7:
  - f_out=0 and busy=0 immediately, without waiting for a clk edge.
  - After release, entry2 reads back as div=50, rep=1.
